// File: rtl/axi_rd_arbiter.sv
// Two-port AXI3 read arbiter: shares one AR/R channel between I and D.
// Routes R beats by RID and holds D reads that hit an in-flight write line.
module axi_rd_arbiter #(
  parameter int unsigned LINE_BYTE_OFFSET = 6,
  parameter int unsigned STARVE_LIMIT     = 4,
  parameter logic [3:0]  I_ID             = 4'd0,
  parameter logic [3:0]  D_ID             = 4'd1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_i_req_valid,
  output logic        o_i_req_ready,
  input  logic [31:0] i_i_addr,
  input  logic [3:0]  i_i_len,
  input  logic [2:0]  i_i_size,
  input  logic        i_d_req_valid,
  output logic        o_d_req_ready,
  input  logic [31:0] i_d_addr,
  input  logic [3:0]  i_d_len,
  input  logic [2:0]  i_d_size,
  input  logic        i_write_process,
  input  logic [31:0] i_write_addr,
  output logic        o_i_rvalid,
  output logic        o_i_rlast,
  output logic        o_d_rvalid,
  output logic        o_d_rlast,
  output logic [31:0] o_rdata,
  output logic        o_rerr,
  output logic        o_err_unexp,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    out_q, out_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    len_q, len_d;
  logic [2:0]    size_q, size_d;
  logic [3:0]    id_q, id_d;
  logic          port_q, port_d;
  logic          err_q, err_d;

  logic hazard;
  logic elig_i;
  logic elig_d;
  logic force_i;
  logic grant_i;
  logic grant_d;
  logic ar_hs;
  logic hit_i;
  logic hit_d;
  logic unexp;

  logic unused_bits;
  assign unused_bits =
    ^{rresp[0], i_write_addr[LINE_BYTE_OFFSET-1:0]};

  // Eligibility and priority between the two requesters
  always_comb begin
    hazard  = i_write_process &
              (i_d_addr[31:LINE_BYTE_OFFSET] ==
               i_write_addr[31:LINE_BYTE_OFFSET]);
    elig_i  = i_i_req_valid & ~out_q[0];
    elig_d  = i_d_req_valid & ~out_q[1] & ~hazard;
    force_i = elig_i & (starve_q == LIM);
    grant_i = (state_q == ST_IDLE) & elig_i &
              (force_i | ~elig_d);
    grant_d = (state_q == ST_IDLE) & elig_d & ~force_i;
  end

  assign o_i_req_ready = grant_i & i_rst_n;
  assign o_d_req_ready = grant_d & i_rst_n;

  // R channel routing by RID against outstanding flags
  always_comb begin
    hit_i = rvalid & (rid == I_ID) & out_q[0];
    hit_d = rvalid & (rid == D_ID) & out_q[1];
    unexp = rvalid & ~hit_i & ~hit_d;
  end

  assign o_i_rvalid  = hit_i;
  assign o_d_rvalid  = hit_d;
  assign o_i_rlast   = hit_i & rlast;
  assign o_d_rlast   = hit_d & rlast;
  assign o_rdata     = rdata;
  assign o_rerr      = rresp[1];
  assign o_err_unexp = err_q;
  assign rready      = i_rst_n;

  assign arvalid = (state_q == ST_ISSUE);
  assign arid    = id_q;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = 2'b01;
  assign ar_hs   = arvalid & arready;

  // AR FSM: latch the granted request, hold it until arready
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    id_d    = id_q;
    port_d  = port_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_i | grant_d) begin
          state_d = ST_ISSUE;
          port_d  = grant_d;
          addr_d  = grant_d ? i_d_addr : i_i_addr;
          len_d   = grant_d ? i_d_len  : i_i_len;
          size_d  = grant_d ? i_d_size : i_i_size;
          id_d    = grant_d ? D_ID     : I_ID;
        end
      end
      ST_ISSUE: begin
        if (arready) state_d = ST_IDLE;
      end
    endcase
  end

  // Outstanding flags: set on AR accept, cleared by routed RLAST
  always_comb begin
    out_d = out_q;
    if (hit_i & rlast) out_d[0] = 1'b0;
    if (hit_d & rlast) out_d[1] = 1'b0;
    if (ar_hs) out_d[port_q] = 1'b1;
  end

  // Starvation counter, evaluated at each grant decision
  always_comb begin
    starve_d = starve_q;
    unique case (1'b1)
      grant_i: starve_d = '0;
      grant_d: begin
        if (!elig_i)
          starve_d = '0;
        else if (starve_q != LIM)
          starve_d = starve_q + SW'(1);
      end
      default: starve_d = starve_q;
    endcase
  end

  // Sticky unexpected-RID flag
  always_comb begin
    err_d = err_q | unexp;
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      id_q     <= '0;
      port_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      id_q     <= id_d;
      port_q   <= port_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: AR and R scoreboards
// fed by the stimulus, compared at the falling edge.
module tb_axi_rd_arbiter;

  localparam logic [3:0] I_ID = 4'd0;
  localparam logic [3:0] D_ID = 4'd1;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_i_req_valid, o_i_req_ready;
  logic [31:0] i_i_addr;
  logic [3:0]  i_i_len;
  logic [2:0]  i_i_size;
  logic        i_d_req_valid, o_d_req_ready;
  logic [31:0] i_d_addr;
  logic [3:0]  i_d_len;
  logic [2:0]  i_d_size;
  logic        i_write_process;
  logic [31:0] i_write_addr;
  logic        o_i_rvalid, o_i_rlast, o_d_rvalid, o_d_rlast;
  logic [31:0] o_rdata;
  logic        o_rerr, o_err_unexp;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 i_clk = ~i_clk;

  axi_rd_arbiter #(
    .LINE_BYTE_OFFSET(6),
    .STARVE_LIMIT(4),
    .I_ID(I_ID),
    .D_ID(D_ID)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_i_req_valid(i_i_req_valid), .o_i_req_ready(o_i_req_ready),
    .i_i_addr(i_i_addr), .i_i_len(i_i_len), .i_i_size(i_i_size),
    .i_d_req_valid(i_d_req_valid), .o_d_req_ready(o_d_req_ready),
    .i_d_addr(i_d_addr), .i_d_len(i_d_len), .i_d_size(i_d_size),
    .i_write_process(i_write_process), .i_write_addr(i_write_addr),
    .o_i_rvalid(o_i_rvalid), .o_i_rlast(o_i_rlast),
    .o_d_rvalid(o_d_rvalid), .o_d_rlast(o_d_rlast),
    .o_rdata(o_rdata), .o_rerr(o_rerr), .o_err_unexp(o_err_unexp),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
  } ar_t;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        last;
    logic        err;
  } bt_t;

  ar_t ar_q[$];
  bt_t bt_q[$];
  int n_chk = 0;
  int n_pass = 0;
  logic [1:0] out_m = 2'b00;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // AR and R monitors
  always @(negedge i_clk) begin : mon
    ar_t a;
    bt_t b;
    if (i_rst_n && arvalid && arready) begin
      if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
      else begin
        a = ar_q.pop_front();
        check("arid", arid, a.id);
        check("araddr", araddr, a.addr);
        check("arlen", arlen, a.len);
        check("arsize", arsize, 3'd2);
        check("arburst", arburst, 2'b01);
      end
    end
    if (i_rst_n && rvalid) begin
      check("rready", rready, 1'b1);
      if (bt_q.size() == 0) check("beat_unexpected", 1, 0);
      else begin
        b = bt_q.pop_front();
        check("rv_i", o_i_rvalid, b.port == 0);
        check("rv_d", o_d_rvalid, b.port == 1);
        check("rlast_i", o_i_rlast, b.port == 0 && b.last);
        check("rlast_d", o_d_rlast, b.port == 1 && b.last);
        check("rdata", o_rdata, b.data);
        check("rerr", o_rerr, b.err);
      end
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_ar(input logic [3:0] id,
                         input logic [31:0] addr,
                         input logic [3:0] len);
    ar_t a;
    a.id = id; a.addr = addr; a.len = len;
    ar_q.push_back(a);
  endtask

  task automatic grant(input logic vi, input logic vd,
                       input logic [31:0] ai, input logic [31:0] ad,
                       input logic [3:0] li, input logic [3:0] ld,
                       output int who);
    i_i_req_valid = vi; i_i_addr = ai; i_i_len = li; i_i_size = 3'd2;
    i_d_req_valid = vd; i_d_addr = ad; i_d_len = ld; i_d_size = 3'd2;
    who = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge i_clk);
      if (o_i_req_ready || o_d_req_ready) begin
        check("rdy_onehot",
              {o_i_req_ready, o_d_req_ready} == 2'b11, 1'b0);
        who = o_i_req_ready ? 0 : 1;
        break;
      end
      cyc();
    end
    if (who < 0) check("grant_timeout", 0, 1);
    cyc();
    i_i_req_valid = 1'b0;
    i_d_req_valid = 1'b0;
  endtask

  task automatic do_ar(input int dly);
    for (int k = 0; k <= dly; k++) begin
      arready = (k == dly);
      @(negedge i_clk);
      check("arvalid_hi", arvalid, 1'b1);
      cyc();
    end
    arready = 1'b0;
    @(negedge i_clk);
    check("arvalid_lo", arvalid, 1'b0);
    cyc();
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] d,
                      input logic last, input logic [1:0] resp);
    bt_t b;
    b.port = (id == I_ID && out_m[0]) ? 0 :
             (id == D_ID && out_m[1]) ? 1 : 2;
    b.data = d; b.last = last; b.err = resp[1];
    bt_q.push_back(b);
    if (last && b.port < 2) out_m[b.port] = 1'b0;
    rvalid = 1'b1; rid = id; rdata = d; rlast = last; rresp = resp;
    cyc();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int who;
    int exp;
    i_rst_n = 1'b0;
    i_i_req_valid = 1'b1; i_i_addr = '0; i_i_len = '0; i_i_size = 3'd2;
    i_d_req_valid = 1'b0; i_d_addr = '0; i_d_len = '0; i_d_size = 3'd2;
    i_write_process = 1'b0; i_write_addr = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0;
    rlast = 1'b0; rvalid = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_i_ready", o_i_req_ready, 1'b0);
    check("rst_err", o_err_unexp, 1'b0);
    i_i_req_valid = 1'b0;
    cyc();
    i_rst_n = 1'b1;
    cyc();

    // single 16-beat I burst, arready after 2 cycles
    push_ar(I_ID, 32'h1FC0_0000, 4'd15);
    grant(1, 0, 32'h1FC0_0000, 0, 4'd15, 0, who);
    check("t1_who", who, 0);
    do_ar(2);
    out_m[0] = 1'b1;
    for (int k = 0; k < 16; k++)
      beat(I_ID, 32'hA000_0000 + 32'(k), k == 15, 2'b00);
    @(negedge i_clk);
    check("t1_out", dut.out_q, 2'b00);
    cyc();

    // starvation: D,D,D,D,I,D
    for (int r = 0; r < 6; r++) begin
      exp = (r == 4) ? 0 : 1;
      push_ar(exp == 1 ? D_ID : I_ID,
              exp == 1 ? 32'h8000 + 32'(r * 64) : 32'h9000 + 32'(r * 64),
              4'd0);
      grant(1, 1, 32'h9000 + 32'(r * 64), 32'h8000 + 32'(r * 64),
            0, 0, who);
      check("starve_order", who, exp);
      do_ar(0);
      out_m[exp] = 1'b1;
      beat(exp == 1 ? D_ID : I_ID, 32'(r), 1'b1, 2'b00);
    end

    // hazard on same line; I still grantable meanwhile
    i_write_process = 1'b1; i_write_addr = 32'h0000_1050;
    i_d_req_valid = 1'b1; i_d_addr = 32'h0000_1040; i_d_len = 4'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check("haz_hold", o_d_req_ready, 1'b0);
      cyc();
    end
    push_ar(I_ID, 32'h0000_2000, 4'd0);
    i_i_req_valid = 1'b1; i_i_addr = 32'h0000_2000; i_i_len = 4'd0;
    @(negedge i_clk);
    check("haz_i_rdy", o_i_req_ready, 1'b1);
    check("haz_d_rdy", o_d_req_ready, 1'b0);
    cyc();
    i_i_req_valid = 1'b0;
    do_ar(0);
    out_m[0] = 1'b1;
    beat(I_ID, 32'h1111_2222, 1'b1, 2'b00);
    @(negedge i_clk);
    check("haz_still", o_d_req_ready, 1'b0);
    cyc();
    i_write_process = 1'b0;
    push_ar(D_ID, 32'h0000_1040, 4'd0);
    @(negedge i_clk);
    check("haz_release", o_d_req_ready, 1'b1);
    cyc();
    i_d_req_valid = 1'b0;
    do_ar(0);
    out_m[1] = 1'b1;
    beat(D_ID, 32'h3333_4444, 1'b1, 2'b00);

    // adjacent line is not a hazard
    i_write_process = 1'b1; i_write_addr = 32'h0000_1000;
    push_ar(D_ID, 32'h0000_1040, 4'd0);
    i_d_req_valid = 1'b1; i_d_addr = 32'h0000_1040;
    @(negedge i_clk);
    check("haz_other_line", o_d_req_ready, 1'b1);
    cyc();
    i_d_req_valid = 1'b0;
    i_write_process = 1'b0;
    do_ar(0);
    out_m[1] = 1'b1;
    beat(D_ID, 32'h5555_6666, 1'b1, 2'b00);

    // two bursts outstanding, interleaved beats
    push_ar(I_ID, 32'h0000_3000, 4'd1);
    grant(1, 0, 32'h0000_3000, 0, 4'd1, 0, who);
    check("il_who_i", who, 0);
    do_ar(1);
    out_m[0] = 1'b1;
    push_ar(D_ID, 32'h0000_4000, 4'd1);
    grant(0, 1, 0, 32'h0000_4000, 0, 4'd1, who);
    check("il_who_d", who, 1);
    do_ar(0);
    out_m[1] = 1'b1;
    @(negedge i_clk);
    check("il_out_both", dut.out_q, 2'b11);
    cyc();
    beat(I_ID, 32'hC000_0000, 1'b0, 2'b00);
    beat(D_ID, 32'hD000_0000, 1'b0, 2'b10);
    beat(I_ID, 32'hC000_0001, 1'b1, 2'b00);
    beat(D_ID, 32'hD000_0001, 1'b1, 2'b00);
    @(negedge i_clk);
    check("il_out_clr", dut.out_q, 2'b00);
    cyc();

    // unexpected RID
    beat(4'd7, 32'hDEAD_BEEF, 1'b1, 2'b00);
    @(negedge i_clk);
    check("unexp_set", o_err_unexp, 1'b1);
    repeat (3) cyc();
    @(negedge i_clk);
    check("unexp_sticky", o_err_unexp, 1'b1);
    cyc();

    // reset with D mid-burst and I in ISSUE
    push_ar(D_ID, 32'h0000_5000, 4'd3);
    grant(0, 1, 0, 32'h0000_5000, 0, 4'd3, who);
    check("rs_who_d", who, 1);
    do_ar(0);
    out_m[1] = 1'b1;
    beat(D_ID, 32'hE000_0000, 1'b0, 2'b00);
    grant(1, 0, 32'h0000_6000, 0, 4'd0, 0, who);
    check("rs_who_i", who, 0);
    @(negedge i_clk);
    check("rs_issue", arvalid, 1'b1);
    #1 i_rst_n = 1'b0;
    #1;
    check("rs_arvalid", arvalid, 1'b0);
    check("rs_out", dut.out_q, 2'b00);
    check("rs_state", dut.state_q, 1'b0);
    check("rs_err", o_err_unexp, 1'b0);
    check("rs_rready", rready, 1'b0);
    out_m = 2'b00;
    cyc();
    cyc();
    i_rst_n = 1'b1;
    cyc();
    beat(D_ID, 32'hE000_0001, 1'b1, 2'b00);
    @(negedge i_clk);
    check("rs_abandoned", o_err_unexp, 1'b1);
    cyc();

    check("ar_sb_empty", ar_q.size(), 0);
    check("beat_sb_empty", bt_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
